rx_word_loader: RTL

RX_WORD_LOADER -- requirements
Module: rx_word_loader

---
 rtl/rx_word_loader.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/rx_word_loader.sv
`default_nettype none
// ============================================================================
// Module      : rx_word_loader
// Description : Assembles little-endian 32-bit words from a UART byte stream
//               and writes them into instruction memory at consecutive word
//               addresses. The all-ones word ends the load. Running out of
//               address space ends the load and raises a sticky overflow flag.
// Ports       : clk        - single clock, rising edge
//               reset      - synchronous, active-high
//               rx_done    - strobe: rx_data holds a received byte
//               rx_data    - received byte
//               start      - re-arms the loader once it has finished
//               wr_en      - one-cycle memory write strobe
//               wr_addr    - word address of the current write
//               wr_data    - assembled word of the current write
//               busy       - a word is partially assembled
//               load_done  - loader has finished (end marker or overflow)
//               overflow   - sticky, address space exhausted
// Revision    : 1.0 - initial release
// ============================================================================
module rx_word_loader #(
    parameter int B      = 8,   // byte width; only 8 is supported
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done,
    input  logic [B-1:0]      rx_data,
    input  logic              start,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              load_done,
    output logic              overflow
);

    localparam logic [1:0]        c_IDLE       = 2'd0;
    localparam logic [1:0]        c_COLLECT    = 2'd1;
    localparam logic [1:0]        c_WRITE      = 2'd2;
    localparam logic [1:0]        c_DONE       = 2'd3;
    localparam logic [ADDR_W-1:0] c_ADDR_MAX   = '1;
    localparam logic [ADDR_W-1:0] c_ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [31:0]       c_END_MARKER = 32'hFFFF_FFFF;

    logic [1:0]        state_q, state_d;
    logic [1:0]        cnt_q,   cnt_d;
    logic [31:0]       word_q,  word_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              ovf_q,   ovf_d;

    // Current word with the incoming byte dropped into the lane selected by
    // the byte count (little-endian: count 0 -> bits [7:0]).
    logic [31:0]       w_word_ins;
    // Fresh word holding only the incoming byte as byte 0.
    logic [31:0]       w_word_first;

    always_comb begin
        w_word_ins                          = word_q;
        w_word_ins[{cnt_q, 3'b000} +: B]    = rx_data;
        w_word_first                        = {{(32-B){1'b0}}, rx_data};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        addr_d  = addr_q;
        ovf_d   = ovf_q;
        case (state_q)
            c_IDLE: begin
                if (rx_done) begin
                    word_d  = w_word_first;
                    cnt_d   = 2'd1;
                    state_d = c_COLLECT;
                end
            end
            c_COLLECT: begin
                if (rx_done) begin
                    word_d = w_word_ins;
                    if (cnt_q == 2'd3) begin
                        cnt_d = 2'd0;
                        // The end marker is recognised as soon as it is
                        // complete, so it never reaches the WRITE state.
                        state_d = (w_word_ins == c_END_MARKER) ? c_DONE : c_WRITE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            c_WRITE: begin
                if (addr_q == c_ADDR_MAX) begin
                    // Last address written: stop and leave the address at
                    // the top so it reflects where loading stopped.
                    ovf_d   = 1'b1;
                    state_d = c_DONE;
                end else begin
                    addr_d = addr_q + c_ADDR_ONE;
                    if (rx_done) begin
                        // A byte arriving in the write cycle starts the next
                        // word; wr_data itself stays stable until the edge.
                        word_d  = w_word_first;
                        cnt_d   = 2'd1;
                        state_d = c_COLLECT;
                    end else begin
                        state_d = c_IDLE;
                    end
                end
            end
            c_DONE: begin
                if (start) begin
                    addr_d  = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = 2'd0;
                    state_d = c_IDLE;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_IDLE;
            cnt_q   <= 2'd0;
            word_q  <= '0;
            addr_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wr_en     = (state_q == c_WRITE);
    assign wr_addr   = addr_q;
    assign wr_data   = word_q;
    assign busy      = (state_q == c_COLLECT);
    assign load_done = (state_q == c_DONE);
    assign overflow  = ovf_q;

endmodule
`default_nettype wire
